// File: rtl/divider_iter.sv
// -----------------------------------------------------------------------------
// divider_iter : iterative restoring integer divider
//
// Each operation is signed or unsigned and is chosen per request.
// BITS_PER_CYCLE quotient bits are retired per clock, so an operation takes
// N = WIDTH/BITS_PER_CYCLE iterations.
// Both sides use a valid/ready handshake, so the block can sit between an
// issue stage and a writeback stage that may stall.
// Divide-by-zero and signed overflow (MIN / -1) both give defined results.
//
// State flow: IDLE -> CALC -> FIX -> DONE -> IDLE.
// o_valid rises N+1 cycles after the accepting edge.
//
// Build option:
//   DIVIDER_ITER_DIVZERO_FASTPATH_EN
//     When defined, a zero divisor goes IDLE -> DONE in one cycle.
//     When undefined, a zero divisor runs the full N+1 cycle latency.
//     The result values are the same in both builds.
//
// Parameters:
//   WIDTH          operand/result width (>= 2)
//   BITS_PER_CYCLE quotient bits per iteration; must divide WIDTH
//
// Ports:
//   i_clk        clock
//   i_rstn       synchronous reset, active low (overrides i_cg)
//   i_cg         clock-gate enable; all state holds while low
//   i_valid      request valid
//   o_ready      request accepted when i_valid && o_ready (IDLE only)
//   i_signed     1: two's-complement operands, 0: unsigned
//   i_dividend   dividend
//   i_divisor    divisor
//   o_valid      result valid, held until taken
//   i_ready      result consumed when o_valid && i_ready
//   o_quotient   quotient (holds last result outside DONE)
//   o_remainder  remainder (holds last result outside DONE)
//   o_divzero    result came from divisor == 0
// -----------------------------------------------------------------------------
module divider_iter #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_cg,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_divzero
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;       // partial remainder
   logic [WIDTH-1:0] r_quo;       // dividend bits shift out MSB-first, quotient bits shift in
   logic [WIDTH-1:0] r_dvs;       // divisor magnitude
   logic [WIDTH-1:0] r_dvd_orig;  // original dividend, returned as the remainder on divide-by-zero
   logic             r_qneg;
   logic             r_rneg;
   logic             r_dz;

   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_divzero;

   logic             w_accept;
   logic             w_take;
   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic             w_dz_in;
   logic             w_fast;

   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   // ---------------------------------------------------------------- operands
   assign w_dvd_neg = i_signed & i_dividend[WIDTH-1];
   assign w_dvs_neg = i_signed & i_divisor[WIDTH-1];
   // -MIN wraps to MIN, and MIN read as unsigned is the correct magnitude 2^(WIDTH-1).
   assign w_dvd_mag = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
   assign w_dvs_mag = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;
   assign w_dz_in   = (i_divisor == '0);

`ifdef DIVIDER_ITER_DIVZERO_FASTPATH_EN
   assign w_fast = w_dz_in;
`else
   assign w_fast = 1'b0;
`endif

   // Handshakes only count on enabled cycles.
   assign w_accept = i_cg & i_valid & (r_state == S_IDLE);
   assign w_take   = i_cg & i_ready & (r_state == S_DONE);

   // ---------------------------------------------------------------- iteration
   // BITS_PER_CYCLE restoring steps are unrolled per clock.
   // The shifted partial remainder is WIDTH+1 bits wide.
   // When the subtraction is kept, the result is below the divisor.
   // So the WIDTH-bit difference is exact.
   always_comb begin
      w_rem_nx = r_rem;
      w_quo_nx = r_quo;
      w_sh     = '0;
      w_diff   = '0;
      w_ge     = 1'b0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         w_sh     = {w_rem_nx, w_quo_nx[WIDTH-1]};
         w_ge     = (w_sh >= {1'b0, r_dvs});
         w_diff   = w_sh[WIDTH-1:0] - r_dvs;
         w_rem_nx = w_ge ? w_diff : w_sh[WIDTH-1:0];
         w_quo_nx = {w_quo_nx[WIDTH-2:0], w_ge};
      end
   end

   // ---------------------------------------------------------------- sign fix
   // A divide-by-zero result overrides whatever the loop produced.
   // This keeps the divzero result the same whichever build option is chosen.
   always_comb begin
      w_q_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
      w_r_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;
      if (r_dz) begin
         w_q_fix = '1;
         w_r_fix = r_dvd_orig;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (i_cg && (r_cnt == CW'(1))) w_next = S_FIX;
         end
         S_FIX: begin
            if (i_cg) w_next = S_DONE;
         end
         S_DONE: begin
            o_valid = 1'b1;
            if (w_take) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_dvd_orig  <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_dz        <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_divzero   <= 1'b0;
      end else if (i_cg) begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_cnt      <= CW'(N);
                  r_rem      <= '0;
                  r_quo      <= w_dvd_mag;
                  r_dvs      <= w_dvs_mag;
                  r_dvd_orig <= i_dividend;
                  r_qneg     <= w_dvd_neg ^ w_dvs_neg;
                  r_rneg     <= w_dvd_neg;
                  r_dz       <= w_dz_in;
                  // The fast path skips FIX, so the result is loaded here.
                  if (w_fast) begin
                     r_quotient  <= '1;
                     r_remainder <= i_dividend;
                     r_divzero   <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt - 1'b1;
            end
            S_FIX: begin
               r_quotient  <= w_q_fix;
               r_remainder <= w_r_fix;
               r_divzero   <= r_dz;
            end
            default: ;
         endcase
      end
   end

   assign o_quotient  = r_quotient;
   assign o_remainder = r_remainder;
   assign o_divzero   = r_divzero;

endmodule

// File: tb/tb_divider_iter.sv
// Bench for divider_iter: one 8-bit/1-bit-per-cycle instance and one
// 16-bit/4-bits-per-cycle instance, both checked against a plain-arithmetic
// reference model.
module tb_divider_iter;

   localparam int LAT8  = 9;
   localparam int LAT16 = 5;
`ifdef DIVIDER_ITER_DIVZERO_FASTPATH_EN
   localparam int DZLAT8  = 1;
   localparam int DZLAT16 = 1;
`else
   localparam int DZLAT8  = 9;
   localparam int DZLAT16 = 5;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 8-bit instance
   logic       a_cg = 1'b1, a_valid = 1'b0, a_rdy, a_sg = 1'b0, a_ov, a_ir = 1'b0, a_dz;
   logic [7:0] a_dvd = '0, a_dvs = '0, a_q, a_r;
   // 16-bit instance
   logic        b_cg = 1'b1, b_valid = 1'b0, b_rdy, b_sg = 1'b0, b_ov, b_ir = 1'b0, b_dz;
   logic [15:0] b_dvd = '0, b_dvs = '0, b_q, b_r;

   divider_iter #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d8 (
      .i_clk(clk), .i_rstn(rstn), .i_cg(a_cg), .i_valid(a_valid), .o_ready(a_rdy),
      .i_signed(a_sg), .i_dividend(a_dvd), .i_divisor(a_dvs), .o_valid(a_ov),
      .i_ready(a_ir), .o_quotient(a_q), .o_remainder(a_r), .o_divzero(a_dz));

   divider_iter #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_d16 (
      .i_clk(clk), .i_rstn(rstn), .i_cg(b_cg), .i_valid(b_valid), .o_ready(b_rdy),
      .i_signed(b_sg), .i_dividend(b_dvd), .i_divisor(b_dvs), .o_valid(b_ov),
      .i_ready(b_ir), .o_quotient(b_q), .o_remainder(b_r), .o_divzero(b_dz));

   // Reference: plain integer division, truncating toward zero, with the
   // remainder taking the dividend's sign.
   function automatic void mdl(input int w, input bit sg, input longint unsigned a,
                               input longint unsigned b, output longint unsigned q,
                               output longint unsigned r, output bit dz);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint sa, sb;
      dz = (b == 0);
      if (dz) begin
         q = mask; r = a;
      end else if (!sg) begin
         q = a / b; r = a % b;
      end else begin
         sa = ((a >> (w-1)) & 1) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
         sb = ((b >> (w-1)) & 1) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
         q = $unsigned(sa / sb) & mask;
         r = $unsigned(sa % sb) & mask;
      end
   endfunction

   // One full transaction on the 8-bit instance; returns result and latency
   // (edges from accept to o_valid, 100 = timed out).
   task automatic run8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz, output int lat);
      a_valid = 1'b1; a_sg = sg; a_dvd = a; a_dvs = b;
      @(posedge clk); #1; a_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (a_ov !== 1'b1 && lat < 100);
      q = a_q; r = a_r; dz = a_dz;
      a_ir = 1'b1; @(posedge clk); #1; a_ir = 1'b0;
   endtask

   task automatic run16(input bit sg, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz, output int lat);
      b_valid = 1'b1; b_sg = sg; b_dvd = a; b_dvs = b;
      @(posedge clk); #1; b_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (b_ov !== 1'b1 && lat < 100);
      q = b_q; r = b_r; dz = b_dz;
      b_ir = 1'b1; @(posedge clk); #1; b_ir = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({a_ov, a_rdy, a_q, a_r, a_dz} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset8 got v=%b rdy=%b q=%h r=%h dz=%b want 0 1 00 00 0", a_ov, a_rdy, a_q, a_r, a_dz);
      end
      checks++;
      if ({b_ov, b_rdy, b_q, b_r, b_dz} !== {1'b0, 1'b1, 16'h0, 16'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset16 got v=%b rdy=%b q=%h r=%h dz=%b want 0 1 0000 0000 0", b_ov, b_rdy, b_q, b_r, b_dz);
      end
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   // Fixed vectors with hand-derived expected values.
   task automatic test_directed();
      bit         tsg [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 1};
      logic [7:0] ta  [9] = '{8'd100, 8'hF9, 8'h80, 8'hFF, 8'h07, 8'h80, 8'h7F, 8'h05, 8'hFB};
      logic [7:0] tb  [9] = '{8'd7,   8'h02, 8'hFF, 8'h01, 8'h09, 8'h01, 8'h81, 8'h00, 8'h00};
      logic [7:0] tq  [9] = '{8'h0E,  8'hFD, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0] tr  [9] = '{8'h02,  8'hFF, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h05, 8'hFB};
      logic       tz  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      logic [7:0] q, r;
      logic       dz;
      int         lat, elat;
      for (int i = 0; i < 9; i++) begin
         run8(tsg[i], ta[i], tb[i], q, r, dz, lat);
         elat = tz[i] ? DZLAT8 : LAT8;
         checks++;
         if ({q, r, dz} !== {tq[i], tr[i], tz[i]} || lat != elat) begin
            errors++;
            $display("FAIL directed[%0d] %h/%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                     i, ta[i], tb[i], tsg[i], q, r, dz, lat, tq[i], tr[i], tz[i], elat);
         end
      end
   endtask

   task automatic test_random8();
      logic [7:0]      a, b, q, r;
      logic            dz;
      bit              sg, edz;
      longint unsigned eq, er;
      int              lat, elat;
      for (int i = 0; i < 300; i++) begin
         sg = 1'($urandom);
         a  = 8'($urandom);
         b  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
         mdl(8, sg, 64'(a), 64'(b), eq, er, edz);
         elat = edz ? DZLAT8 : LAT8;
         run8(sg, a, b, q, r, dz, lat);
         checks++;
         if ({q, r, dz} !== {eq[7:0], er[7:0], edz} || lat != elat) begin
            errors++;
            $display("FAIL rand8 %h/%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                     a, b, sg, q, r, dz, lat, eq[7:0], er[7:0], edz, elat);
         end
      end
   endtask

   // Result held in DONE while the consumer stalls; one handoff on release.
   task automatic test_back_to_back();
      logic [7:0] q, r;
      logic       dz;
      int         lat;
      a_valid = 1'b1; a_sg = 1'b0; a_dvd = 8'd100; a_dvs = 8'd7;
      @(posedge clk); #1; a_valid = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (a_ov !== 1'b1 && lat < 100);
      checks++;
      if (lat != LAT8) begin
         errors++;
         $display("FAIL stall_lat got %0d want %0d", lat, LAT8);
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({a_ov, a_rdy, a_q, a_r, a_dz} !== {1'b1, 1'b0, 8'h0E, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b rdy=%b q=%h r=%h dz=%b want 1 0 0e 02 0",
                     c, a_ov, a_rdy, a_q, a_r, a_dz);
         end
      end
      a_ir = 1'b1; @(posedge clk); #1; a_ir = 1'b0;
      checks++;
      if ({a_ov, a_rdy} !== 2'b01) begin
         errors++;
         $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", a_ov, a_rdy);
      end
      run8(1'b0, 8'd200, 8'd3, q, r, dz, lat);
      checks++;
      if ({q, r, dz} !== {8'd66, 8'd2, 1'b0} || lat != LAT8) begin
         errors++;
         $display("FAIL b2b got q=%0d r=%0d dz=%b lat=%0d want q=66 r=2 dz=0 lat=%0d", q, r, dz, lat, LAT8);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] q, r;
      logic       dz;
      int         lat;
      bit         seen;
      a_valid = 1'b1; a_sg = 1'b0; a_dvd = 8'h50; a_dvs = 8'd3;
      @(posedge clk); #1; a_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1; rstn = 1'b0;
      @(posedge clk); #1; rstn = 1'b1;
      checks++;
      if ({a_ov, a_rdy} !== 2'b01) begin
         errors++;
         $display("FAIL rst_mid_state got v=%b rdy=%b want v=0 rdy=1", a_ov, a_rdy);
      end
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (a_ov === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_mid_novalid got o_valid seen=1 want 0");
      end
      run8(1'b0, 8'd200, 8'd3, q, r, dz, lat);
      checks++;
      if ({q, r, dz} !== {8'd66, 8'd2, 1'b0} || lat != LAT8) begin
         errors++;
         $display("FAIL rst_mid_next got q=%0d r=%0d dz=%b lat=%0d want q=66 r=2 dz=0 lat=%0d", q, r, dz, lat, LAT8);
      end
   endtask

   // Clock-gate low freezes everything, including handshakes.
   task automatic test_clock_gate();
      int lat;
      a_cg = 1'b0; a_valid = 1'b1; a_sg = 1'b0; a_dvd = 8'd100; a_dvs = 8'd7;
      @(posedge clk); #1;
      checks++;
      if (a_rdy !== 1'b1) begin
         errors++;
         $display("FAIL cg_noaccept got rdy=%b want 1", a_rdy);
      end
      a_cg = 1'b1;
      @(posedge clk); #1; a_valid = 1'b0;
      lat = 0;
      do begin
         if (lat == 2) a_cg = 1'b0;
         if (lat == 7) a_cg = 1'b1;
         @(posedge clk); #1; lat++;
      end while (a_ov !== 1'b1 && lat < 100);
      checks++;
      if (lat != LAT8 + 5 || a_q !== 8'h0E || a_r !== 8'h02) begin
         errors++;
         $display("FAIL cg_calc got lat=%0d q=%h r=%h want lat=%0d q=0e r=02", lat, a_q, a_r, LAT8 + 5);
      end
      a_cg = 1'b0; a_ir = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_ov !== 1'b1) begin
         errors++;
         $display("FAIL cg_nohandoff got v=%b want 1", a_ov);
      end
      a_cg = 1'b1;
      @(posedge clk); #1; a_ir = 1'b0;
      checks++;
      if ({a_ov, a_rdy} !== 2'b01) begin
         errors++;
         $display("FAIL cg_handoff got v=%b rdy=%b want v=0 rdy=1", a_ov, a_rdy);
      end
   endtask

   task automatic test_random16();
      logic [15:0]     a, b, q, r;
      logic            dz;
      bit              sg, edz;
      longint unsigned eq, er;
      int              lat, elat, sel;
      for (int i = 0; i < 4000; i++) begin
         sg  = 1'($urandom);
         a   = 16'($urandom);
         sel = $urandom_range(0, 15);
         if (sel == 0)      b = 16'h0000;
         else if (sel == 1) begin b = 16'hFFFF; a = 16'h8000; sg = 1'b1; end
         else if (sel < 6)  b = 16'($urandom_range(1, 15));
         else               b = 16'($urandom);
         mdl(16, sg, 64'(a), 64'(b), eq, er, edz);
         elat = edz ? DZLAT16 : LAT16;
         run16(sg, a, b, q, r, dz, lat);
         checks++;
         if ({q, r, dz} !== {eq[15:0], er[15:0], edz} || lat != elat) begin
            errors++;
            $display("FAIL rand16 %h/%h s=%b got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                     a, b, sg, q, r, dz, lat, eq[15:0], er[15:0], edz, elat);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random8();
      test_back_to_back();
      test_reset_mid();
      test_clock_gate();
      test_random16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
